// File: rtl/seg7_mux.sv
`default_nettype none
// ============================================================================
//  Module   : seg7_mux
//  Purpose  : Two-digit multiplexed seven-segment driver. Latches a byte on a
//             load strobe and shows it as two hex digits, alternating between
//             digits every DIV clocks, with per-slot dead time against ghosting
//             and a free-running 16-step PWM for dimming.
//  Ports    : clk_16mhz  in  1  system clock, rising edge
//             rst        in  1  asynchronous active-high reset
//             value      in  8  byte to display
//             load       in  1  single-cycle strobe latching value
//             blank      in  1  forces all segments off while high
//             brightness in  4  duty level, on-time (brightness+1)/16
//             seg        out 7  segment drives, active-high, seg[0]=a..seg[6]=g
//             digit_sel  out 1  0 = right digit (low nibble), 1 = left digit
//  Revision : 1.0  initial release
// ============================================================================
module seg7_mux #(
    parameter int CLK_HZ     = 16_000_000,
    parameter int REFRESH_HZ = 1000,
    parameter int DEAD       = 16
) (
    input  logic       clk_16mhz,
    input  logic       rst,
    input  logic [7:0] value,
    input  logic       load,
    input  logic       blank,
    input  logic [3:0] brightness,
    output logic [6:0] seg,
    output logic       digit_sel
);

    localparam int DIV   = CLK_HZ / REFRESH_HZ;
    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] CNT_DEAD = CNT_W'(DEAD);

    logic [7:0]       value_q,     value_d;
    logic [CNT_W-1:0] ref_cnt_q,   ref_cnt_d;
    logic             digit_q,     digit_d;
    logic [3:0]       pwm_cnt_q,   pwm_cnt_d;
    logic [6:0]       seg_q,       seg_d;
    logic             digit_sel_q, digit_sel_d;

    logic [3:0]       nib;
    logic [6:0]       dec;
    logic             on;

    always_comb begin
        value_d = load ? value : value_q;

        if (ref_cnt_q == CNT_LAST) begin
            ref_cnt_d = '0;
            digit_d   = ~digit_q;
        end else begin
            ref_cnt_d = ref_cnt_q + 1'b1;
            digit_d   = digit_q;
        end

        // Free-running; intentionally not re-aligned at slot boundaries.
        pwm_cnt_d = pwm_cnt_q + 4'd1;

        nib = digit_q ? value_q[7:4] : value_q[3:0];

        // gfedcba
        case (nib)
            4'h0:    dec = 7'h3F;
            4'h1:    dec = 7'h06;
            4'h2:    dec = 7'h5B;
            4'h3:    dec = 7'h4F;
            4'h4:    dec = 7'h66;
            4'h5:    dec = 7'h6D;
            4'h6:    dec = 7'h7D;
            4'h7:    dec = 7'h07;
            4'h8:    dec = 7'h7F;
            4'h9:    dec = 7'h6F;
            4'hA:    dec = 7'h77;
            4'hB:    dec = 7'h7C;
            4'hC:    dec = 7'h39;
            4'hD:    dec = 7'h5E;
            4'hE:    dec = 7'h79;
            default: dec = 7'h71;
        endcase

        on = !blank && (ref_cnt_q >= CNT_DEAD) && (pwm_cnt_q <= brightness);

        // seg and digit_sel are both derived from the pre-edge snapshot of
        // digit_q/ref_cnt_q/value_q, so they always change together.
        seg_d       = on ? dec : 7'h00;
        digit_sel_d = digit_q;
    end

    always_ff @(posedge clk_16mhz or posedge rst) begin
        if (rst) begin
            value_q     <= 8'h00;
            ref_cnt_q   <= '0;
            digit_q     <= 1'b0;
            pwm_cnt_q   <= 4'd0;
            seg_q       <= 7'h00;
            digit_sel_q <= 1'b0;
        end else begin
            value_q     <= value_d;
            ref_cnt_q   <= ref_cnt_d;
            digit_q     <= digit_d;
            pwm_cnt_q   <= pwm_cnt_d;
            seg_q       <= seg_d;
            digit_sel_q <= digit_sel_d;
        end
    end

    assign seg       = seg_q;
    assign digit_sel = digit_sel_q;

endmodule
`default_nettype wire

// File: doc/seg7_mux.md
# seg7_mux

Two-digit multiplexed seven-segment driver that consumes the 8-bit result produced by the WTFpga `top` logic and drives the display on `pmod_b`. It latches a byte on a load strobe and shows it as two hex digits, time-multiplexed at a parameterised refresh rate. Per-digit dead-time suppresses ghosting, and a 16-step PWM dims the display. It sits directly downstream of the switch/logic stage, in the same 16 MHz domain.

## Interface
- `CLK_HZ`, 16_000_000: input clock frequency.
- `REFRESH_HZ`, 1000: per-digit slot rate. `DIV = CLK_HZ/REFRESH_HZ` is the slot length in clocks.
- `DEAD`, 16: blanking clocks at the start of each slot. Must satisfy `0 <= DEAD < DIV`.

Ports:
- `clk_16mhz` in 1: system clock. All logic is on its rising edge.
- `rst` in 1: reset, asynchronous and active-high.
- `value` in 8: byte to display.
- `load` in 1: single-cycle strobe that latches `value`.
- `blank` in 1: forces all segments off while high.
- `brightness` in 4: duty level. 15 gives 16/16 on-time, 0 gives 1/16.
- `seg` out 7: segment drives, active-high. `seg[0]`=a … `seg[6]`=g. Maps to `pmod_b[6:0]`.
- `digit_sel` out 1: 0 selects the right digit (low nibble), 1 selects the left digit (high nibble). Maps to `pmod_b[7]`.

## Operation
Internal state:
- `value_q` (8b) holds the displayed byte.
- `ref_cnt` runs 0..DIV-1.
- `digit` (1b) is the current slot's digit.
- `pwm_cnt` (4b) is free-running.

Behaviour:
- **Load:** `load`=1 at an edge sets `value_q <= value`. If `load` is held, the latest `value` is taken on every cycle. `value` is ignored while `load`=0.
- **Slot counting:** `ref_cnt` increments each cycle. When `ref_cnt == DIV-1`, the next cycle sets `ref_cnt=0` and `digit = ~digit`.
- **PWM counter:** `pwm_cnt` increments each cycle and wraps 15 -> 0. It is not aligned to slots.
- **Nibble select:** `nib = digit ? value_q[7:4] : value_q[3:0]`.
- **Hex decode** (gfedcba, hex):
  - 0:3F, 1:06, 2:5B, 3:4F, 4:66, 5:6D, 6:7D, 7:07
  - 8:7F, 9:6F, A:77, b:7C, C:39, d:5E, E:79, F:71
- **Segment enable:** `on = !blank && (ref_cnt >= DEAD) && (pwm_cnt <= brightness)`.
- **Registered outputs:** each cycle `seg <= on ? decode(nib) : 7'h00` and `digit_sel <= digit`. Both are computed from the same state snapshot, so they never disagree by a cycle.
- **Arithmetic:** counter widths are `$clog2(DIV)`. The `pwm_cnt <= brightness` comparison is unsigned 4-bit.

## Timing
- **Reset values:** `seg=0`, `digit_sel=0`, `value_q=0`, `ref_cnt=0`, `digit=0`, `pwm_cnt=0`.
  - Reset asserted mid-slot clears everything immediately, with outputs going low asynchronously.
  - After release, the first slot is digit 0 and begins with DEAD blanked clocks.
- **Load latency:** `load` sampled at edge n updates `value_q` after edge n. `seg` reflects the new value after edge n+1, provided the relevant digit is active and enabled.
- **Load coinciding with a slot boundary:** the new value is shown in the new slot from its first lit cycle. There is no tearing within a lit cycle.
- **Slot length:** each digit slot is exactly DIV clocks on `digit_sel`. The full frame is 2·DIV clocks.
- **Dead time:** within a slot, `seg` is 0 for the first DEAD cycles. These are registered cycles following the `digit_sel` change.
  - With DEAD=0, segments may be lit from the first cycle of the slot.
- **Blank:** `blank` affects `seg` one cycle after it is sampled. It does not stop the counters or `digit_sel`.
- **Brightness:** a change applies one cycle after it is sampled. Lit-cycle duty over any 16 consecutive cycles outside dead time is `(brightness+1)/16`.

## Test plan
Use `DIV=32` (set `CLK_HZ=32000`, `REFRESH_HZ=1000`), `DEAD=4`, `brightness=15` unless stated otherwise.

- **Reset:** assert `rst` mid-slot -> `seg=00` and `digit_sel=0` immediately. After release, `digit_sel` toggles every 32 clocks and `seg` is 0 for the first 4 cycles of each slot.
- **Load and decode:** load `value=8'hA5` -> the digit 0 slot shows `seg=6D` and the digit 1 slot shows `seg=77`. Check that load at edge n gives the new `seg` after edge n+1 while digit 0 is lit.
- **Full decode sweep:** load 00, 11, … FF in turn -> each digit matches the decode list above.
- **Dimming:** `brightness=0` -> outside dead time, exactly 1 lit cycle per 16. `brightness=7` -> exactly 8 lit cycles per 16.
- **Blank:** hold `blank=1` for 100 cycles -> `seg=00` throughout while `digit_sel` keeps toggling. After `blank` deasserts, the display resumes with the previously loaded value.
- **Boundary load:** pulse `load` (value 3C) on the cycle where `ref_cnt=31` -> the new slot shows the new nibble on its first lit cycle. `digit_sel` and `seg` never come from different snapshots.
